div: RTL and testbench
======================

# div

Multi-cycle 32-bit integer divider for the `div`/`divu` instructions. It sits beside the execute stage. Execute supplies the operands and a start request, and holds `stallreq_from_ex` high until `ready_o` rises. The 64-bit result then leaves execute on the HI/LO write path: HI receives the remainder and LO receives the quotient. The divider is a radix-2 restoring design that produces one quotient bit per cycle.

## Interface
- No parameters.
- `clk`  in  1  — the only clock; all state updates on its rising edge.
- `rst`  in  1  — synchronous, active-high reset.
- `signed_div_i`  in  1  — 1 selects signed division (`div`); 0 selects unsigned (`divu`).
- `opdata1_i`  in  32  — dividend. Sampled only on the start edge.
- `opdata2_i`  in  32  — divisor. Sampled only on the start edge.
- `start_i`  in  1  — request from execute. Held high until execute sees `ready_o`.
- `annul_i`  in  1  — cancels an operation in progress (flush or exception).
- `result_o`  out  64  — `{remainder, quotient}`. Registered.
- `ready_o`  out  1  — result valid. Registered.

## Operation
- **States:** FREE, BYZERO, ON, END. State, `cnt[5:0]`, `dividend[64:0]`, the latched divisor, the latched operand signs and both outputs are all registers.
- **Reset:** state FREE, `cnt` 0, `result_o` 0, `ready_o` 0. Reset takes priority over every other condition, including mid-operation.
- **FREE**
  - If `start_i` is 1 and `annul_i` is 0:
    - Divisor 0: go to BYZERO.
    - Otherwise: go to ON with `cnt` = 0.
  - Otherwise: stay in FREE with both outputs held at 0.
- **Operand latching on the start edge**
  - If `signed_div_i` is 1, each negative operand is replaced by its two's-complement absolute value.
  - `0x80000000` maps to unsigned `0x80000000`.
  - `dividend` is loaded with `{32'b0, |opdata1|, 1'b0}`.
  - The signs of both operands are latched.
- **ON, `cnt` < 32** (one iteration per cycle)
  - Compute `diff` = `dividend[63:32]` − divisor, 33 bits wide.
  - If `diff` is negative: `dividend <= {dividend[63:0], 1'b0}`.
  - Otherwise: `dividend <= {diff[31:0], dividend[31:0], 1'b1}`.
  - Then `cnt <= cnt + 1`.
- **ON, `cnt` = 32**
  - Quotient is `dividend[31:0]`; remainder is `dividend[64:33]`.
  - Signed mode: negate the quotient if the operand signs differ, and negate the remainder if the dividend was negative.
  - Load `result_o = {remainder, quotient}`, set `ready_o` = 1, go to END.
- **BYZERO:** load `result_o` = 0, set `ready_o` = 1, go to END.
- **END**
  - While `start_i` is 1: hold the result and `ready_o`.
  - When `start_i` is 0: go to FREE and clear `result_o` and `ready_o`.
- **Annul:** `annul_i` = 1 in ON or BYZERO sends the block to FREE at the next edge with outputs cleared. `annul_i` has no effect in END.
- **Signed overflow:** `0x80000000 / 0xFFFFFFFF` gives quotient `0x80000000` and remainder 0. No trap is raised.
- **Mid-operation input changes:** new `opdata*_i` or `signed_div_i` values after the start edge are ignored.
- **Back-to-back operations:** a new start is accepted only in FREE. The earliest is one cycle after END is left.

## Timing
- **Normal division:** start is sampled at edge 0, giving FREE→ON. Iterations occur at edges 1–32, and the finalize step at edge 33. `ready_o` is high from edge 33 onward, so execute stalls for 33 cycles after issue.
- **Divide by zero:** FREE→BYZERO at edge 0, END at edge 1. `ready_o` is high from edge 1.
- **Hand-back:** `ready_o` stays high at least one cycle. Execute lowers `start_i` in the cycle it observes `ready_o`, and the divider reaches FREE at the following edge.
- **Combinational paths:** none from inputs to outputs. `result_o` and `ready_o` change only on clock edges.
- **Simultaneous events:** `rst` dominates `annul_i`, which dominates `start_i`.

## Test plan
- **Unsigned:** `divu` 100 / 7 → `ready_o` after 33 edges, `result_o` = `0x00000002_0000000E`. Result holds while `start_i` stays high, and both outputs are 0 one edge after `start_i` drops.
- **Signed, both mixed-sign cases:**
  - `div` −7 / 2 → `0xFFFFFFFF_FFFFFFFD` (r = −1, q = −3).
  - `div` 7 / −2 → `0x00000001_FFFFFFFD`.
- **Divide by zero and max values:**
  - `divu` `0x12345678` / 0 → `ready_o` at edge 1, `result_o` = 0.
  - `divu` `0xFFFFFFFF` / 1 → `0x00000000_FFFFFFFF`.
- **Signed overflow:** `div` `0x80000000` / `0xFFFFFFFF` → `0x00000000_80000000`.
- **Annul:** assert `annul_i` at iteration 10 → FREE next edge, `ready_o` never rises. An immediate new start 20 / 3 → `0x00000002_00000006` with full latency.
- **Reset and input stability:**
  - Assert `rst` for 1 cycle at iteration 20 → all outputs 0 and state FREE. A later operation completes correctly.
  - Change the operands mid-operation → no effect on the result.

Source files
------------

// File: rtl/div.sv
// Radix-2 restoring 32-bit divider for div/divu; result is {remainder, quotient}.
module div (
    input  logic        clk,
    input  logic        rst,
    input  logic        signed_div_i,
    input  logic [31:0] opdata1_i,
    input  logic [31:0] opdata2_i,
    input  logic        start_i,
    input  logic        annul_i,
    output logic [63:0] result_o,
    output logic        ready_o
);

    localparam int unsigned DW = 32;

    typedef enum logic [1:0] {
        ST_FREE   = 2'd0,
        ST_BYZERO = 2'd1,
        ST_ON     = 2'd2,
        ST_END    = 2'd3
    } state_t;

    state_t              state_q,    state_d;
    logic [5:0]          cnt_q,      cnt_d;
    logic [2*DW:0]       dividend_q, dividend_d;
    logic [DW-1:0]       divisor_q,  divisor_d;
    logic                neg1_q,     neg1_d;
    logic                neg2_q,     neg2_d;
    logic [2*DW-1:0]     result_q,   result_d;
    logic                ready_q,    ready_d;

    logic [DW:0]         diff;
    logic                op1_neg;
    logic                op2_neg;
    logic [DW-1:0]       abs1;
    logic [DW-1:0]       abs2;
    logic [DW-1:0]       quot;
    logic [DW-1:0]       rem;

    // Operand conditioning, trial subtraction and sign correction of the final result.
    always_comb begin
        op1_neg = signed_div_i & opdata1_i[DW-1];
        op2_neg = signed_div_i & opdata2_i[DW-1];
        abs1    = op1_neg ? (~opdata1_i + DW'(1)) : opdata1_i;
        abs2    = op2_neg ? (~opdata2_i + DW'(1)) : opdata2_i;
        diff    = {1'b0, dividend_q[2*DW-1:DW]} - {1'b0, divisor_q};
        quot    = (neg1_q ^ neg2_q) ? (~dividend_q[DW-1:0] + DW'(1)) : dividend_q[DW-1:0];
        rem     = neg1_q ? (~dividend_q[2*DW:DW+1] + DW'(1)) : dividend_q[2*DW:DW+1];
    end

    // Next-state and next-output logic; annul outranks start, and is ignored in END.
    always_comb begin
        state_d    = state_q;
        cnt_d      = cnt_q;
        dividend_d = dividend_q;
        divisor_d  = divisor_q;
        neg1_d     = neg1_q;
        neg2_d     = neg2_q;
        result_d   = result_q;
        ready_d    = ready_q;

        case (state_q)
            ST_FREE: begin
                result_d = '0;
                ready_d  = 1'b0;
                if (start_i && !annul_i) begin
                    divisor_d  = abs2;
                    neg1_d     = op1_neg;
                    neg2_d     = op2_neg;
                    dividend_d = {DW'(0), abs1, 1'b0};
                    cnt_d      = 6'd0;
                    state_d    = (opdata2_i == '0) ? ST_BYZERO : ST_ON;
                end
            end
            ST_BYZERO: begin
                if (annul_i) begin
                    result_d = '0;
                    ready_d  = 1'b0;
                    state_d  = ST_FREE;
                end else begin
                    result_d = '0;
                    ready_d  = 1'b1;
                    state_d  = ST_END;
                end
            end
            ST_ON: begin
                if (annul_i) begin
                    result_d = '0;
                    ready_d  = 1'b0;
                    state_d  = ST_FREE;
                end else if (cnt_q != 6'd32) begin
                    if (diff[DW]) begin
                        dividend_d = {dividend_q[2*DW-1:0], 1'b0};
                    end else begin
                        dividend_d = {diff[DW-1:0], dividend_q[DW-1:0], 1'b1};
                    end
                    cnt_d = cnt_q + 6'd1;
                end else begin
                    result_d = {rem, quot};
                    ready_d  = 1'b1;
                    state_d  = ST_END;
                end
            end
            ST_END: begin
                if (!start_i) begin
                    result_d = '0;
                    ready_d  = 1'b0;
                    state_d  = ST_FREE;
                end
            end
            default: begin
                state_d = ST_FREE;
            end
        endcase
    end

    // State and output registers with synchronous reset.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q    <= ST_FREE;
            cnt_q      <= 6'd0;
            dividend_q <= '0;
            divisor_q  <= '0;
            neg1_q     <= 1'b0;
            neg2_q     <= 1'b0;
            result_q   <= '0;
            ready_q    <= 1'b0;
        end else begin
            state_q    <= state_d;
            cnt_q      <= cnt_d;
            dividend_q <= dividend_d;
            divisor_q  <= divisor_d;
            neg1_q     <= neg1_d;
            neg2_q     <= neg2_d;
            result_q   <= result_d;
            ready_q    <= ready_d;
        end
    end

    assign result_o = result_q;
    assign ready_o  = ready_q;

endmodule

// File: tb/tb_div.sv
// Directed, table-driven bench for the multi-cycle divider.
module tb_div;

    logic        clk;
    logic        rst;
    logic        signed_div_i;
    logic [31:0] opdata1_i;
    logic [31:0] opdata2_i;
    logic        start_i;
    logic        annul_i;
    logic [63:0] result_o;
    logic        ready_o;

    int n_checks;
    int n_fail;

    div dut (
        .clk          (clk),
        .rst          (rst),
        .signed_div_i (signed_div_i),
        .opdata1_i    (opdata1_i),
        .opdata2_i    (opdata2_i),
        .start_i      (start_i),
        .annul_i      (annul_i),
        .result_o     (result_o),
        .ready_o      (ready_o)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct {
        logic        sgn;
        logic [31:0] a;
        logic [31:0] b;
        logic [63:0] exp;
        int          lat;
    } vec_t;

    vec_t vecs[10];

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    // Issue one operation, hold it, poke annul in END, then release start.
    task automatic run_op(input string tag, input logic sgn, input logic [31:0] a,
                          input logic [31:0] b, input logic [63:0] exp, input int lat,
                          input bit perturb);
        int n;
        logic [63:0] res;
        signed_div_i = sgn;
        opdata1_i    = a;
        opdata2_i    = b;
        start_i      = 1'b1;
        n = 0;
        while (1) begin
            @(posedge clk); #1;
            n++;
            if (perturb && n == 5) begin
                opdata1_i    = 32'hDEAD_BEEF;
                opdata2_i    = 32'h0000_0003;
                signed_div_i = ~sgn;
            end
            if (ready_o || n > 60) break;
        end
        check({tag, " ready"}, 64'(ready_o), 64'd1);
        check({tag, " latency"}, 64'(n - 1), 64'(lat));
        check({tag, " result"}, result_o, exp);
        res = result_o;
        @(posedge clk); #1;
        check({tag, " hold ready"}, 64'(ready_o), 64'd1);
        check({tag, " hold result"}, result_o, res);
        annul_i = 1'b1;
        @(posedge clk); #1;
        annul_i = 1'b0;
        check({tag, " end annul ready"}, 64'(ready_o), 64'd1);
        check({tag, " end annul result"}, result_o, res);
        start_i = 1'b0;
        @(posedge clk); #1;
        check({tag, " drop ready"}, 64'(ready_o), 64'd0);
        check({tag, " drop result"}, result_o, 64'd0);
    endtask

    initial begin
        int highs;
        n_checks = 0;
        n_fail   = 0;

        vecs[0] = '{1'b0, 32'd100,        32'd7,          64'h00000002_0000000E, 33};
        vecs[1] = '{1'b1, 32'hFFFF_FFF9,  32'd2,          64'hFFFFFFFF_FFFFFFFD, 33};
        vecs[2] = '{1'b1, 32'd7,          32'hFFFF_FFFE,  64'h00000001_FFFFFFFD, 33};
        vecs[3] = '{1'b0, 32'h1234_5678,  32'd0,          64'h00000000_00000000, 1};
        vecs[4] = '{1'b0, 32'hFFFF_FFFF,  32'd1,          64'h00000000_FFFFFFFF, 33};
        vecs[5] = '{1'b1, 32'h8000_0000,  32'hFFFF_FFFF,  64'h00000000_80000000, 33};
        vecs[6] = '{1'b0, 32'h8000_0000,  32'hFFFF_FFFF,  64'h80000000_00000000, 33};
        vecs[7] = '{1'b1, 32'hFFFF_FFF9,  32'hFFFF_FFFE,  64'hFFFFFFFF_00000003, 33};
        vecs[8] = '{1'b0, 32'hFFFF_FFFF,  32'hFFFF_FFFF,  64'h00000000_00000001, 33};
        vecs[9] = '{1'b1, 32'd0,          32'd0,          64'h00000000_00000000, 1};

        rst          = 1'b1;
        signed_div_i = 1'b0;
        opdata1_i    = '0;
        opdata2_i    = '0;
        start_i      = 1'b0;
        annul_i      = 1'b0;
        repeat (2) @(posedge clk);
        #1;
        check("reset ready", 64'(ready_o), 64'd0);
        check("reset result", result_o, 64'd0);
        rst = 1'b0;
        @(posedge clk); #1;

        for (int i = 0; i < 10; i++) begin
            run_op($sformatf("vec%0d", i), vecs[i].sgn, vecs[i].a, vecs[i].b,
                   vecs[i].exp, vecs[i].lat, 1'b0);
        end

        // Annul at iteration 10, then an immediate fresh start.
        signed_div_i = 1'b0;
        opdata1_i    = 32'd100;
        opdata2_i    = 32'd7;
        start_i      = 1'b1;
        highs = 0;
        repeat (11) begin
            @(posedge clk); #1;
            if (ready_o) highs++;
        end
        annul_i = 1'b1;
        start_i = 1'b0;
        @(posedge clk); #1;
        annul_i = 1'b0;
        if (ready_o) highs++;
        check("annul ready never", 64'(highs), 64'd0);
        check("annul result", result_o, 64'd0);
        run_op("after annul", 1'b0, 32'd20, 32'd3, 64'h00000002_00000006, 33, 1'b0);

        // Reset at iteration 20, stays idle afterwards, then a normal operation.
        signed_div_i = 1'b0;
        opdata1_i    = 32'd100;
        opdata2_i    = 32'd7;
        start_i      = 1'b1;
        repeat (21) begin
            @(posedge clk); #1;
        end
        rst     = 1'b1;
        start_i = 1'b0;
        @(posedge clk); #1;
        rst = 1'b0;
        check("midrst ready", 64'(ready_o), 64'd0);
        check("midrst result", result_o, 64'd0);
        highs = 0;
        repeat (40) begin
            @(posedge clk); #1;
            if (ready_o) highs++;
        end
        check("midrst idle ready", 64'(highs), 64'd0);
        run_op("after reset", 1'b1, 32'hFFFF_FFF9, 32'd2, 64'hFFFFFFFF_FFFFFFFD, 33, 1'b0);

        // Operand changes after the start edge must not affect the result.
        run_op("perturb", 1'b0, 32'd100, 32'd7, 64'h00000002_0000000E, 33, 1'b1);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
